// File: rtl/alt_run_detector_if.sv
// -----------------------------------------------------------------------------
// alt_run_detector_if
// Groups the sample stream and the detector results into one bundle.
//   en      : sample valid, x is sampled only when en=1
//   x       : serial data bit
//   clr     : synchronous clear, has priority over en
//   z       : registered hit pulse
//   run_len : current alternating-run length (registered)
//   active  : run in progress with run_len >= 2
//   hit_cnt : 16-bit hit counter, present only with ALT_HIT_COUNT_EN defined
// Modports: master = stream source / result consumer, slave = detector.
// -----------------------------------------------------------------------------
interface alt_run_detector_if #(
   parameter int CNT_W = 8
);
   logic             en;
   logic             x;
   logic             clr;
   logic             z;
   logic [CNT_W-1:0] run_len;
   logic             active;
`ifdef ALT_HIT_COUNT_EN
   logic [15:0]      hit_cnt;

   modport master (output en, x, clr, input z, run_len, active, hit_cnt);
   modport slave  (input en, x, clr, output z, run_len, active, hit_cnt);
`else
   modport master (output en, x, clr, input z, run_len, active);
   modport slave  (input en, x, clr, output z, run_len, active);
`endif
endinterface : alt_run_detector_if

// File: rtl/alt_run_detector.sv
// -----------------------------------------------------------------------------
// alt_run_detector
// Detects runs of alternating bits (0101... / 1010...) on a qualified serial
// stream. Tracks the current run length and pulses z when the run reaches
// MIN_LEN. OVERLAP=1 keeps hitting while the run continues; OVERLAP=0 restarts
// after each hit.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-low
//   bus  : alt_run_detector_if.slave (en, x, clr in; z, run_len, active out)
// Optional feature macro: ALT_HIT_COUNT_EN adds bus.hit_cnt, a 16-bit wrapping
// count of edges that loaded z with 1.
// -----------------------------------------------------------------------------
module alt_run_detector #(
   parameter int MIN_LEN = 4,
   parameter int CNT_W   = 8,
   parameter bit OVERLAP = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   alt_run_detector_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [CNT_W-1:0] LEN_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LEN_HIT = CNT_W'(MIN_LEN);
   localparam logic [CNT_W-1:0] LEN_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] LEN_TWO = CNT_W'(2);

   state_t           state_q, state_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] run_len_q, run_len_d;
   logic             z_q, z_d;
   logic [CNT_W-1:0] new_len;
`ifdef ALT_HIT_COUNT_EN
   logic [15:0]      hit_cnt_q, hit_cnt_d;
`endif

   // State register
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         last_q    <= 1'b0;
         run_len_q <= '0;
         z_q       <= 1'b0;
`ifdef ALT_HIT_COUNT_EN
         hit_cnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         run_len_q <= run_len_d;
         z_q       <= z_d;
`ifdef ALT_HIT_COUNT_EN
         hit_cnt_q <= hit_cnt_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d   = state_q;
      last_d    = last_q;
      run_len_d = run_len_q;
      z_d       = 1'b0;
      // Length the run would have if this sample is taken in RUN;
      // saturates instead of wrapping.
      if (bus.x != last_q)
         new_len = (run_len_q == LEN_MAX) ? LEN_MAX : run_len_q + LEN_ONE;
      else
         new_len = LEN_ONE;

      if (bus.clr) begin
         state_d   = IDLE;
         last_d    = 1'b0;
         run_len_d = '0;
      end else if (bus.en) begin
         last_d = bus.x;
         if (state_q == IDLE) begin
            state_d   = RUN;
            run_len_d = LEN_ONE;
         end else if (OVERLAP) begin
            run_len_d = new_len;
            z_d       = (new_len >= LEN_HIT);
         end else if (new_len == LEN_HIT) begin
            // Non-overlapping: a hit consumes the run, next sample starts fresh
            state_d   = IDLE;
            run_len_d = '0;
            z_d       = 1'b1;
         end else begin
            run_len_d = new_len;
         end
      end

`ifdef ALT_HIT_COUNT_EN
      if (bus.clr)
         hit_cnt_d = '0;
      else if (z_d)
         hit_cnt_d = hit_cnt_q + 16'd1;
      else
         hit_cnt_d = hit_cnt_q;
`endif
   end

   // Output logic: decoded from registered state only, no path from x
   always_comb begin
      bus.z       = z_q;
      bus.run_len = run_len_q;
      bus.active  = (state_q == RUN) && (run_len_q >= LEN_TWO);
`ifdef ALT_HIT_COUNT_EN
      bus.hit_cnt = hit_cnt_q;
`endif
   end

endmodule : alt_run_detector

// File: tb/tb_alt_run_detector.sv
// -----------------------------------------------------------------------------
// tb_alt_run_detector
// Three detector instances share one stimulus stream:
//   A: MIN_LEN=4, CNT_W=8, OVERLAP=1
//   B: MIN_LEN=4, CNT_W=8, OVERLAP=0
//   C: MIN_LEN=4, CNT_W=3, OVERLAP=1 (saturation)
// Each table entry names the instance whose outputs it checks.
// -----------------------------------------------------------------------------
module tb_alt_run_detector;

   typedef struct {
      int         dut;
      logic       en;
      logic       x;
      logic       clr;
      logic       exp_z;
      logic [7:0] exp_len;
      logic       exp_active;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en  = 1'b0;
   logic x   = 1'b0;
   logic clr = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alt_run_detector_if #(.CNT_W(8)) if_a ();
   alt_run_detector_if #(.CNT_W(8)) if_b ();
   alt_run_detector_if #(.CNT_W(3)) if_c ();

   assign if_a.en = en;  assign if_a.x = x;  assign if_a.clr = clr;
   assign if_b.en = en;  assign if_b.x = x;  assign if_b.clr = clr;
   assign if_c.en = en;  assign if_c.x = x;  assign if_c.clr = clr;

   alt_run_detector #(.MIN_LEN(4), .CNT_W(8), .OVERLAP(1'b1)) dut_a (
      .clk (clk), .rst (rst), .bus (if_a.slave));
   alt_run_detector #(.MIN_LEN(4), .CNT_W(8), .OVERLAP(1'b0)) dut_b (
      .clk (clk), .rst (rst), .bus (if_b.slave));
   alt_run_detector #(.MIN_LEN(4), .CNT_W(3), .OVERLAP(1'b1)) dut_c (
      .clk (clk), .rst (rst), .bus (if_c.slave));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input int d, input logic e, input logic xb, input logic c,
                               input logic ez, input int el, input logic ea);
      vec_t v;
      v.dut = d; v.en = e; v.x = xb; v.clr = c;
      v.exp_z = ez; v.exp_len = 8'(el); v.exp_active = ea;
      return v;
   endfunction

   task automatic sel_out(input int d, output logic oz, output logic [7:0] olen, output logic oa);
      case (d)
         0: begin oz = if_a.z; olen = if_a.run_len;           oa = if_a.active; end
         1: begin oz = if_b.z; olen = if_b.run_len;           oa = if_b.active; end
         default: begin oz = if_c.z; olen = {5'b0, if_c.run_len}; oa = if_c.active; end
      endcase
   endtask

   task automatic do_reset();
      @(negedge clk);
      en = 1'b0; clr = 1'b0; x = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic run_table(input string tname, input vec_t tbl[$]);
      logic       oz, oa;
      logic [7:0] olen;
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         en = tbl[i].en; x = tbl[i].x; clr = tbl[i].clr;
         @(posedge clk);
         #1;
         sel_out(tbl[i].dut, oz, olen, oa);
         check($sformatf("%s[%0d].z", tname, i), 32'(oz), 32'(tbl[i].exp_z));
         check($sformatf("%s[%0d].run_len", tname, i), 32'(olen), 32'(tbl[i].exp_len));
         check($sformatf("%s[%0d].active", tname, i), 32'(oa), 32'(tbl[i].exp_active));
      end
      @(negedge clk);
      en = 1'b0; clr = 1'b0;
   endtask

   vec_t t1[$], t2[$], t3[$], t4[$], t5[$], t6[$], t7[$];

   initial begin
      // 1: overlapping run of six, then an idle sample drops z but holds state
      t1 = '{mk(0,1,0,0,0,1,0), mk(0,1,1,0,0,2,1), mk(0,1,0,0,0,3,1),
             mk(0,1,1,0,1,4,1), mk(0,1,0,0,1,5,1), mk(0,1,1,0,1,6,1),
             mk(0,0,0,0,0,6,1)};
      // 2: non-overlapping restarts after each hit
      t2 = '{mk(1,1,1,0,0,1,0), mk(1,1,0,0,0,2,1), mk(1,1,1,0,0,3,1),
             mk(1,1,0,0,1,0,0), mk(1,1,1,0,0,1,0), mk(1,1,0,0,0,2,1),
             mk(1,1,1,0,0,3,1), mk(1,1,0,0,1,0,0)};
      // 3: repeated bit starts a new run at length 1
      t3 = '{mk(0,1,0,0,0,1,0), mk(0,1,1,0,0,2,1), mk(0,1,1,0,0,1,0),
             mk(0,1,0,0,0,2,1), mk(0,1,1,0,0,3,1), mk(0,1,0,0,1,4,1)};
      // 4: en gaps hold state while x toggles
      t4 = '{mk(0,1,0,0,0,1,0), mk(0,0,1,0,0,1,0), mk(0,0,0,0,0,1,0),
             mk(0,0,1,0,0,1,0), mk(0,1,1,0,0,2,1), mk(0,1,0,0,0,3,1),
             mk(0,1,1,0,1,4,1)};
      // 5: 3-bit counter saturates at 7, z stays high
      t5 = '{mk(2,1,0,0,0,1,0), mk(2,1,1,0,0,2,1), mk(2,1,0,0,0,3,1),
             mk(2,1,1,0,1,4,1), mk(2,1,0,0,1,5,1), mk(2,1,1,0,1,6,1),
             mk(2,1,0,0,1,7,1), mk(2,1,1,0,1,7,1), mk(2,1,0,0,1,7,1),
             mk(2,1,1,0,1,7,1)};
      // 6: clr beats a hitting sample, next sample treated as IDLE
      t6 = '{mk(0,1,0,0,0,1,0), mk(0,1,1,0,0,2,1), mk(0,1,0,0,0,3,1),
             mk(0,1,1,1,0,0,0), mk(0,1,0,0,0,1,0)};
      // 7: build a run of five before the asynchronous reset
      t7 = '{mk(0,1,0,0,0,1,0), mk(0,1,1,0,0,2,1), mk(0,1,0,0,0,3,1),
             mk(0,1,1,0,1,4,1), mk(0,1,0,0,1,5,1)};

      rst = 1'b0;
      #12;
      check("reset.z",       32'(if_a.z),       32'd0);
      check("reset.run_len", 32'(if_a.run_len), 32'd0);
      check("reset.active",  32'(if_a.active),  32'd0);
      @(negedge clk);
      rst = 1'b1;

      run_table("ovl", t1);
`ifdef ALT_HIT_COUNT_EN
      check("ovl.hit_cnt", 32'(if_a.hit_cnt), 32'd3);
`endif
      do_reset();
      run_table("novl", t2);
`ifdef ALT_HIT_COUNT_EN
      check("novl.hit_cnt", 32'(if_b.hit_cnt), 32'd2);
`endif
      do_reset();
      run_table("repeat", t3);
      do_reset();
      run_table("gaps", t4);
      do_reset();
      run_table("sat", t5);
      do_reset();
      run_table("clr", t6);
`ifdef ALT_HIT_COUNT_EN
      check("clr.hit_cnt", 32'(if_a.hit_cnt), 32'd0);
`endif
      do_reset();
      run_table("prerst", t7);

      // Asynchronous reset mid-cycle: outputs clear without a clock edge
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("asyncrst.z",       32'(if_a.z),       32'd0);
      check("asyncrst.run_len", 32'(if_a.run_len), 32'd0);
      check("asyncrst.active",  32'(if_a.active),  32'd0);
`ifdef ALT_HIT_COUNT_EN
      check("asyncrst.hit_cnt", 32'(if_a.hit_cnt), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b1;
      // First sample after release starts a fresh run
      @(negedge clk);
      en = 1'b1; x = 1'b1;
      @(posedge clk);
      #1;
      check("postrst.run_len", 32'(if_a.run_len), 32'd1);
      check("postrst.z",       32'(if_a.z),       32'd0);
      @(negedge clk);
      en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_alt_run_detector
